// File: rtl/dp_ram_pkg.sv
// Shared definitions for the parametrised dual-port RAM.
//   state_e        : clear-engine FSM states
//   RW_OLD/RW_NEW  : read-during-write collision modes
//   addr_in_range  : unsigned address-vs-depth check used by both ports
package dp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned RW_OLD = 0;
  localparam int unsigned RW_NEW = 1;

  // Both operands are widened to 64 bits so the compare is always unsigned
  // and independent of ADDR_W.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read output register chain, STAGES deep (1 or 2).
//   clk, rst_n : clock, asynchronous active-low reset
//   vld_i      : a read result is presented on data_i this cycle
//   data_i     : read result entering the chain
//   data_o     : last stage data, held when no new result arrives
//   vld_o      : last stage valid, one pulse per accepted read
module dp_ram_rd_pipe #(
  parameter int DATA_W = 4,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o
);

  logic [DATA_W-1:0] data_p [STAGES];
  logic              vld_p  [STAGES];

  // Stage p0 captures the array output; each later stage copies its
  // predecessor. Data only moves with its valid so outputs hold between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= vld_i;
      if (vld_i) data_p[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign data_o = data_p[STAGES-1];
  assign vld_o  = vld_p[STAGES-1];

endmodule

// File: rtl/dp_ram_param.sv
// Parametrised single-clock dual-port RAM (one write port, one read port)
// with a hardware clear engine and out-of-range detection.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   write_en/write_addr/write_data    : write port, ignored while init_busy
//   read_en/read_addr                 : read port, ignored while init_busy
//   clear_req                         : pulse to zero the whole array
//   read_data/read_valid              : read result READ_LAT cycles later
//   init_busy                         : clear engine running
//   addr_err                          : previous cycle used an address >= DEPTH
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1,
  parameter int RW_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic              clear_req,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              init_busy,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             addr_err_q, addr_err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_in, rd_in;
  logic              wr_ok, rd_acc, rd_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign ready  = (state_q == ST_READY);
  assign wr_in  = addr_in_range(64'(write_addr), 64'(DEPTH));
  assign rd_in  = addr_in_range(64'(read_addr), 64'(DEPTH));
  assign wr_ok  = ready && write_en && wr_in;
  assign rd_acc = ready && read_en;          // out-of-range reads still return a valid
  assign rd_ok  = rd_acc && rd_in;
  // Truncation is safe: the index is only used once the range check passed.
  assign wr_idx = write_addr[IDX_W-1:0];
  assign rd_idx = read_addr[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    addr_err_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_cnt_d = '0;
        end
      end
      ST_READY: begin
        addr_err_d = (write_en && !wr_in) || (read_en && !rd_in);
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // The array has no reset; the clear engine owns the write port while busy.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) mem[clr_cnt_q] <= '0;
    else if (wr_ok)          mem[wr_idx]    <= write_data;
  end

  // Combinational array read feeding the first pipe stage. On a same-address
  // collision the array still holds the old word this cycle, so RW_OLD falls
  // out naturally and RW_NEW needs an explicit bypass.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if (RW_MODE == RW_NEW && wr_ok && write_addr == read_addr) rd_word = write_data;
      else                                                       rd_word = mem[rd_idx];
    end
  end

  dp_ram_rd_pipe #(
    .DATA_W(DATA_W),
    .STAGES(READ_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (rd_acc),
    .data_i(rd_word),
    .data_o(read_data),
    .vld_o (read_valid)
  );

  assign init_busy = (state_q == ST_CLEAR);
  assign addr_err  = addr_err_q;

endmodule

// File: doc/dp_ram_param.md
Name: dp_ram_param

Overview:
Parametrised successor to the 256x4 dual-port RAM: one write port and one read port, both synchronous to a single clock. It adds configurable width, depth and read latency, and a selectable read-during-write collision mode. A hardware clear engine zeroes the array after reset or on request, and out-of-range accesses raise an error flag. It is the storage primitive for the buffer and FIFO blocks that follow in this design.

Parameters:
DATA_W, 4, data word width in bits (1..64)
DEPTH, 256, number of words (2..2**ADDR_W; need not be a power of two)
ADDR_W, 8, address port width in bits
READ_LAT, 1, read latency in cycles; legal values 1 or 2
RW_MODE, 0, same-address read/write in one cycle: 0 = read returns old data, 1 = read returns new data (write-through)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
write_en  in  1  write request, honoured only when init_busy=0
write_addr  in  ADDR_W  write address
write_data  in  DATA_W  write data
read_en  in  1  read request, honoured only when init_busy=0
read_addr  in  ADDR_W  read address
clear_req  in  1  single-cycle pulse requesting a full array clear
read_data  out  DATA_W  read result, valid when read_valid=1, held otherwise
read_valid  out  1  read_data carries the result of a read issued READ_LAT cycles earlier
init_busy  out  1  clear engine active; all accesses ignored
addr_err  out  1  one-cycle pulse: a request in the previous cycle used an address >= DEPTH

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. Reset forces FSM=CLEAR, clr_cnt=0, read_data=0, read_valid=0, addr_err=0, init_busy=1 and flushes the read pipeline. The array itself is not reset; the clear engine zeroes it.
- FSM states are CLEAR and READY.
- CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. When clr_cnt=DEPTH-1, the FSM moves to READY on the next edge. CLEAR therefore lasts exactly DEPTH cycles. init_busy=1 whenever FSM=CLEAR.
- READY: clear_req=1 sets clr_cnt=0 and moves the FSM to CLEAR. clear_req is ignored while in CLEAR.
- During CLEAR, write_en, read_en and addr_err detection are ignored. No read_valid is generated.
- Write: in READY with write_en=1 and write_addr<DEPTH, mem[write_addr] takes write_data at the edge.
- Read: in READY with read_en=1 and read_addr<DEPTH, the data is captured.
  - READ_LAT=1: read_data and read_valid are updated at the next edge.
  - READ_LAT=2: one extra output register stage is added.
  - read_valid is a pulse per accepted read. Back-to-back reads give back-to-back valids with no bubbles.
- Out-of-range: a request with addr>=DEPTH is dropped.
  - For writes, memory is unchanged.
  - For reads, read_valid still asserts with read_data=0.
  - addr_err=1 for the cycle after the offending request. If both ports are out of range in one cycle, this is still a single pulse.
- Collision (write_en and read_en both set, same in-range address):
  - RW_MODE=0 returns the pre-write contents.
  - RW_MODE=1 returns write_data.
- Different-address simultaneous read and write: no interaction.
- Read pipeline content in flight when clear_req is accepted: it is still delivered with its original data.
- Reset asserted mid-CLEAR or mid-read: the clear restarts from address 0 and pending read_valids are discarded.
- Width rules: addresses are compared unsigned against DEPTH. Indexing a non-existent word is never allowed.

Decomposition:
- Shared package dp_ram_pkg holds:
  - FSM state enum {ST_CLEAR, ST_READY}
  - RW_OLD=0 and RW_NEW=1 constants
  - a function returning the address range check
- One natural sub-module: dp_ram_rd_pipe, the READ_LAT-deep data/valid output register chain with async reset.
- The array and the clear FSM stay in the top module.

Test Plan:
- Release rst_n, default params: init_busy=1 for exactly 256 cycles, then 0. A read of 0x0A then returns read_data=0x0 with read_valid one cycle later.
- Write 0xA@0x00, 0xC@0x01, 0x3@0x0A, then read 0x00, 0x0A, 0x01 back-to-back: read_data is 0xA, 0x3, 0xC on three consecutive valid cycles.
- DEPTH=200, ADDR_W=8:
  - Write 0x5@0xFF: addr_err pulses once.
  - Read 0xFF: read_valid=1, read_data=0, addr_err pulses.
  - mem[0xC7] is unaffected.
- Preload 0x6@0x10, then same-cycle write 0x9 and read @0x10:
  - RW_MODE=0 returns 0x6.
  - RW_MODE=1 returns 0x9.
  - A subsequent read returns 0x9 in both modes.
- READ_LAT=2 with reads issued on cycles N and N+1: read_valid is set on N+2 and N+3 with correct data. Asserting rst_n=0 at N+1 clears read_valid immediately and no valid appears.
- After writing nonzero data, pulse clear_req: init_busy=1 for DEPTH cycles and a write issued mid-clear is ignored. Afterwards all probed addresses read 0. A clear_req issued during CLEAR does not extend the clear.
